// File: rtl/sound_pkg.sv
// Shared types, constants and duty-ramp helpers for the speaker PWM path.
package sound_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } PWM_STATE;

    localparam logic [7:0] MIDSCALE = 8'd128;
    localparam logic [7:0] PWM_MAX  = 8'd255;

    // Move duty one step toward midscale from either side, landing exactly on it.
    function automatic logic [7:0] step_toward_mid(input logic [7:0] duty,
                                                   input logic [7:0] step);
        logic [8:0] up;
        logic [8:0] down;
        logic [7:0] result;
        up   = {1'b0, duty} + {1'b0, step};
        down = {1'b0, duty} - {1'b0, step};
        if (duty < MIDSCALE) begin
            result = (up > {1'b0, MIDSCALE}) ? MIDSCALE : up[7:0];
        end else if (duty > MIDSCALE) begin
            result = (down < {1'b0, MIDSCALE}) ? MIDSCALE : down[7:0];
        end else begin
            result = MIDSCALE;
        end
        return result;
    endfunction

    // Move duty one step toward zero, clamping at zero instead of wrapping.
    function automatic logic [7:0] step_toward_zero(input logic [7:0] duty,
                                                    input logic [7:0] step);
        logic [8:0] down;
        logic [7:0] result;
        down = {1'b0, duty} - {1'b0, step};
        if ({1'b0, duty} <= {1'b0, step}) begin
            result = 8'd0;
        end else begin
            result = down[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Prescaler plus 8-bit PWM phase counter; flags the last tick of each period.
module pwm_counter
    import sound_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       nRst,
    output logic [7:0] cnt,
    output logic       boundary
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick     = (presc == PRESC_LAST);
    assign boundary = tick && (cnt == PWM_MAX);

    // Prescaler and phase counter; cnt advances once per tick and wraps 255 -> 0.
    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!nRst) begin
            presc <= '0;
            cnt   <= 8'd0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= cnt + 8'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/dac_pwm_driver.sv
// Turns 8-bit sound samples into a speaker PWM bit, latching samples only at
// period boundaries and ramping duty to/from midscale on enable changes.
module dac_pwm_driver
    import sound_pkg::*;
#(
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] dacCount_i,
    input  logic       enable_i,
    output logic       pwm_o,
    output logic       period_o,
    output logic       active_o
);

    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    logic [7:0] cnt;
    logic       boundary;
    PWM_STATE   state;
    PWM_STATE   state_next;
    logic [7:0] duty;
    logic [7:0] duty_next;
    logic       period_q;
    logic       active_q;

    pwm_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clk      (clk),
        .nRst     (nRst),
        .cnt      (cnt),
        .boundary (boundary)
    );

    // Mute state machine: state moves on any clock, duty only at a boundary,
    // and the duty update always follows the pre-edge state.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        state_next = state;
        duty_next  = duty;
        case (state)
            OFF: begin
                duty_next = 8'd0;
                if (enable_i) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (boundary) duty_next = step_toward_mid(duty, STEP);
                if (!enable_i)              state_next = RAMP_DOWN;
                else if (duty == MIDSCALE)  state_next = PLAY;
            end
            PLAY: begin
                if (boundary) duty_next = dacCount_i;
                if (!enable_i) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (boundary) duty_next = step_toward_zero(duty, STEP);
                if (enable_i)           state_next = RAMP_UP;
                else if (duty == 8'd0)  state_next = OFF;
            end
            default: begin
                state_next = OFF;
                duty_next  = 8'd0;
            end
        endcase
    end

    // State, duty and registered status flags.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= OFF;
            duty     <= 8'd0;
            period_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_next;
            duty     <= duty_next;
            period_q <= boundary;
            active_q <= (state_next == PLAY);
        end
    end

    assign pwm_o    = (cnt < duty);
    assign period_o = period_q;
    assign active_o = active_q;

endmodule

// File: tb/tb_dac_pwm_driver.sv
// Directed bench for dac_pwm_driver with PRESCALE=1, RAMP_STEP=16.
module tb_dac_pwm_driver;
    import sound_pkg::*;

    logic       tb_clk;
    logic       nRst;
    logic [7:0] dacCount_i;
    logic       enable_i;
    logic       pwm_o;
    logic       period_o;
    logic       active_o;

    int n_cmp = 0;
    int n_bad = 0;

    dac_pwm_driver #(
        .PRESCALE  (1),
        .RAMP_STEP (16)
    ) dut (
        .clk        (tb_clk),
        .nRst       (nRst),
        .dacCount_i (dacCount_i),
        .enable_i   (enable_i),
        .pwm_o      (pwm_o),
        .period_o   (period_o),
        .active_o   (active_o)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Starting at the negedge after a boundary, sample one full period
    // (256 clocks), optionally changing the sample twice mid-period.
    task automatic run_period(output int highs, output int act1,
                              input int t1, input logic [7:0] v1,
                              input int t2, input logic [7:0] v2);
        highs = 0;
        act1  = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == t1) dacCount_i = v1;
            if (i == t2) dacCount_i = v2;
            highs += int'(pwm_o);
            @(negedge tb_clk);
            if (i == 0) act1 = int'(active_o);
        end
        check("period_strobe", int'(period_o), 1);
    endtask

    // Count strobes and outputs over a window right after reset release.
    task automatic idle_window(input string tag, input int clocks, input int exp_pulses);
        int pulses;
        int first;
        int prev;
        int bad_gaps;
        int highs;
        int acts;
        pulses = 0; first = -1; prev = -1; bad_gaps = 0; highs = 0; acts = 0;
        for (int i = 1; i <= clocks; i++) begin
            @(negedge tb_clk);
            highs += int'(pwm_o);
            acts  += int'(active_o);
            if (period_o) begin
                pulses++;
                if (first < 0) first = i;
                if (prev >= 0 && (i - prev) != 256) bad_gaps++;
                prev = i;
            end
        end
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_first"}, first, 256);
        check({tag, "_gaps"}, bad_gaps, 0);
        check({tag, "_pwm_high"}, highs, 0);
        check({tag, "_active"}, acts, 0);
    endtask

    int highs;
    int act1;

    initial begin
        nRst       = 1'b0;
        enable_i   = 1'b0;
        dacCount_i = 8'd0;
        repeat (3) @(negedge tb_clk);
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_period", int'(period_o), 0);
        check("rst_active", int'(active_o), 0);
        nRst = 1'b1;

        // Idle: four strobes 256 clocks apart, output silent.
        idle_window("idle", 1024, 4);

        // Ramp up from OFF: 0, then 16..128.
        enable_i   = 1'b1;
        dacCount_i = 8'd128;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("up_duty0", highs, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) check("up_active_at_128", int'(active_o), 0);
            run_period(highs, act1, -1, 8'd0, -1, 8'd0);
            check($sformatf("up_duty%0d", 16 * k), highs, 16 * k);
            if (k == 8) check("up_enter_play", act1, 1);
        end
        check("play_active", int'(active_o), 1);

        // PLAY: samples latched at boundaries only.
        dacCount_i = 8'd64;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("play_128", highs, 128);
        dacCount_i = 8'd255;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("play_64", highs, 64);
        dacCount_i = 8'd0;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("play_255", highs, 255);
        dacCount_i = 8'd200;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("play_0", highs, 0);
        run_period(highs, act1, 100, 8'd30, 180, 8'd160);
        check("play_midtoggle", highs, 200);

        // Disable from duty 160, re-enable at 96.
        enable_i = 1'b0;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("dn_160", highs, 160);
        check("dn_active_fall", act1, 0);
        for (int k = 1; k <= 3; k++) begin
            run_period(highs, act1, -1, 8'd0, -1, 8'd0);
            check($sformatf("dn_%0d", 160 - 16 * k), highs, 160 - 16 * k);
        end
        enable_i   = 1'b1;
        dacCount_i = 8'd224;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("reup_96", highs, 96);
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("reup_112", highs, 112);
        check("reup_112_active", act1, 0);
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("reup_128", highs, 128);
        check("reup_play", act1, 1);
        dacCount_i = 8'd200;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("reup_sample", highs, 224);

        // Disable from duty 200: 184 .. 8, then 0 and OFF.
        enable_i = 1'b0;
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("off_200", highs, 200);
        check("off_active_fall", act1, 0);
        for (int k = 1; k <= 12; k++) begin
            run_period(highs, act1, -1, 8'd0, -1, 8'd0);
            check($sformatf("off_%0d", 200 - 16 * k), highs, 200 - 16 * k);
        end
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("off_zero", highs, 0);
        check("off_state", int'(dut.state), int'(OFF));
        run_period(highs, act1, -1, 8'd0, -1, 8'd0);
        check("off_stays_low", highs, 0);

        // Back to PLAY at full scale, then reset mid-period.
        enable_i   = 1'b1;
        dacCount_i = 8'd255;
        for (int k = 0; k <= 8; k++) begin
            run_period(highs, act1, -1, 8'd0, -1, 8'd0);
            check($sformatf("rup_%0d", 16 * k), highs, 16 * k);
        end
        repeat (50) @(negedge tb_clk);
        check("pre_rst_pwm", int'(pwm_o), 1);
        check("pre_rst_active", int'(active_o), 1);
        #2;
        nRst     = 1'b0;
        enable_i = 1'b0;
        #1;
        check("async_rst_pwm", int'(pwm_o), 0);
        check("async_rst_period", int'(period_o), 0);
        check("async_rst_active", int'(active_o), 0);
        @(negedge tb_clk);
        nRst = 1'b1;
        idle_window("post_rst", 512, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
